aes_key_expansion_seq: RTL
==========================

// Module: aes_key_expansion_seq
// PURPOSE
// - Iterative AES-256 key schedule. Expands a 256-bit cipher key into the 15 round keys (60 words) used by the round ladder.
// - Sits directly upstream of the round ladder and drives its packed round-key vector input.
// - Computes one 32-bit word per clock, so one rekey takes 52 cycles.
// - The output vector holds its value between rekeys. The ladder datapath therefore sees a static key set.
// PARAMETERS
// - NB_BYTE   8   bits per byte; only 8 supported
// - N_BYTES   16  bytes per state / round key; only 16 supported
// - N_ROUNDS  14  AES rounds; only 14 (AES-256) supported; the vector carries N_ROUNDS+1 keys
// - NB_KEY    256 cipher key width; only 256 supported
// PORTS
// - i_clock             in   1     sole clock, rising edge
// - i_reset_n           in   1     asynchronous, active-low reset
// - i_key               in   256   cipher key; i_key[255:224] = w[0], byte 0 in MSBs
// - i_key_valid         in   1     start request; sampled only when o_ready=1
// - o_ready             out  1     1 = IDLE, start accepted this cycle
// - o_valid             out  1     1 = o_round_key_vector holds a complete, correct schedule
// - o_round_key_vector  out  1920  round key k at [k*128 +: 128]; word w[4k] at bits [k*128+96 +: 32]
// BEHAVIOUR
// - Reset (async assert, sync deassert by the upstream reset synchroniser):
//   - FSM=IDLE, o_ready=1, o_valid=0.
//   - o_round_key_vector=0, word index=0, rcon=8'h01.
// - FSM states: IDLE, EXPAND.
// - IDLE with i_key_valid=1 (accept cycle):
//   - Store i_key into w[0..7], i.e. vector slots 0 and 1.
//   - Set index=8, rcon=8'h01, o_valid<=0, o_ready<=0, go to EXPAND.
// - EXPAND, each cycle, with t = w[i-1]:
//   - i%8==0: w[i] = w[i-8] ^ SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon <= xtime(rcon).
//   - i%8==4: w[i] = w[i-8] ^ SubWord(t).
//   - otherwise: w[i] = w[i-8] ^ t.
//   - Write w[i] into its slot; index <= index+1.
// - Exit: when index==59 is written, go to IDLE next edge; o_valid=1 and o_ready=1 in the following cycle.
// - Latency: accept at edge N gives o_valid=1 and o_ready=1 from edge N+52.
// - Rcon range is 01..40. xtime includes the 0x1B reduction for generality; it is never exercised for AES-256.
// - i_key_valid during EXPAND is ignored; there is no queueing. Upstream must hold the request until o_ready.
// - Rekey while o_valid=1: o_valid drops the cycle after accept. Slots 2..14 keep stale data until overwritten.
//   Consumers must gate on o_valid.
// - i_key is sampled only in the accept cycle; changes afterwards have no effect.
// - Reset asserted mid-EXPAND: immediate return to reset state; no partial o_valid.
// - All arithmetic is GF(2^8) XOR/xtime. No carries, no widths beyond 32 bits in the datapath.
// - BAD_CONF: any parameter outside the supported set is a configuration error, flagged by a local BAD_CONF localparam.
// STRUCTURE
// - Shared include aes_defs: NB_BYTE, N_BYTES, N_WORDS_KEY=8, N_WORDS_TOTAL=60, the FSM state encodings, and the xtime function.
// - Sub-module aes_subword_block: 4 parallel S-box instances, purely combinational, 32 bits in and 32 bits out.
//   - It is the only S-box use in this block.
//   - Its select mux chooses RotWord(t) or t.
// - Datapath contents:
//   - Word register file: 60x32, written one word per cycle.
//   - Window: w[i-1] is taken from the last written word; w[i-8] is read by index mux.
//   - 6-bit index counter, 8-bit rcon register, 1-bit FSM.
// - Expected RTL size is 150-250 lines, plus the sub-module.
// TESTING
// - FIPS-197 C.3 key 000102..1f:
//   - o_valid exactly 52 cycles after accept.
//   - Key 14 = 24fc79cc_bf0979e9_371ac23c_6d68de36.
//   - Key 1 = 10111213_14151617_18191a1b_1c1d1e1f.
// - FIPS-197 A.3 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4:
//   - w[8] = 9ba35411.
//   - w[56..59] = fe4890d1_e6188d0b_046df344_706c631e.
// - Hold i_key_valid=1 continuously from C.3:
//   - Second accept happens one cycle after o_valid rises.
//   - o_valid pulses low for exactly 52 cycles, then the same vector returns.
// - Pulse i_key_valid with the A.3 key at cycle 20 of a C.3 expansion:
//   - The pulse is ignored; the C.3 result completes unchanged.
// - Drop i_reset_n at cycle 30 of an expansion:
//   - Outputs go to reset values without waiting for a clock edge.
//   - A new A.3 accept after release yields the correct A.3 schedule.
// - Random keys (1000), checked against the C reference model:
//   - Full 1920-bit compare at every o_valid rise.
//   - Assertions: o_ready and o_valid never both 0 while in IDLE after the first completion; o_ready==0 throughout EXPAND.

Source files
------------

// File: rtl/aes_key_expansion_seq_pkg.sv
// Shared AES-256 key-schedule constants, FSM encoding, S-box table and GF(2^8) helpers.
// Pure definitions: no latency, no flow control.
package aes_key_expansion_seq_pkg;

    localparam int AES_NB_BYTE   = 8;
    localparam int AES_N_BYTES   = 16;
    localparam int AES_N_ROUNDS  = 14;
    localparam int AES_NB_KEY    = 256;
    localparam int WORD_W        = 32;
    localparam int N_WORDS_KEY   = 8;
    localparam int N_WORDS_TOTAL = 60;
    localparam int RK_W          = AES_N_BYTES * AES_NB_BYTE;
    localparam int VEC_W         = (AES_N_ROUNDS + 1) * RK_W;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/aes_key_expansion_seq_if.sv
// Key request / round-key vector bundle between the key source and the key-schedule block.
// Request is a level held until ready; the vector is static while valid is high.
interface aes_key_expansion_seq_if;

    logic [255:0]  i_key;
    logic          i_key_valid;
    logic          o_ready;
    logic          o_valid;
    logic [1919:0] o_round_key_vector;

    modport slave (
        input  i_key,
        input  i_key_valid,
        output o_ready,
        output o_valid,
        output o_round_key_vector
    );

    modport master (
        output i_key,
        output i_key_valid,
        input  o_ready,
        input  o_valid,
        input  o_round_key_vector
    );

endinterface

// File: rtl/aes_key_expansion_seq_subword.sv
// SubWord with optional RotWord in front: four parallel S-box lookups, 32 bits in and out.
// Purely combinational, zero latency, no flow control.
module aes_key_expansion_seq_subword
    import aes_key_expansion_seq_pkg::*;
(
    input  logic [WORD_W-1:0] t_i,
    input  logic              rot_i,
    output logic [WORD_W-1:0] sub_o
);

    logic [WORD_W-1:0] sel;

    assign sel = rot_i ? {t_i[23:0], t_i[31:24]} : t_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub_o[8*b +: 8] = sbox(sel[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_expansion_seq.sv
// Iterative AES-256 key schedule, one 32-bit word per clock: accept to valid takes 52 cycles.
// Ready only in IDLE; requests during expansion are ignored, the vector is held between rekeys.
module aes_key_expansion_seq
    import aes_key_expansion_seq_pkg::*;
#(
    parameter int NB_BYTE  = 8,
    parameter int N_BYTES  = 16,
    parameter int N_ROUNDS = 14,
    parameter int NB_KEY   = 256
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    aes_key_expansion_seq_if.slave bus
);

    localparam bit BAD_CONF = (NB_BYTE != AES_NB_BYTE) || (N_BYTES != AES_N_BYTES) ||
                              (N_ROUNDS != AES_N_ROUNDS) || (NB_KEY != AES_NB_KEY);

    if (BAD_CONF) begin : g_bad_conf
        $error("aes_key_expansion_seq: only AES-256 with 8-bit bytes and 16-byte blocks is supported");
    end

    state_e                                 state_q, state_d;
    logic [5:0]                             idx_q, idx_d;
    logic [7:0]                             rcon_q, rcon_d;
    logic                                   valid_q, valid_d;
    logic [WORD_W-1:0]                      last_q, last_d;
    logic [N_WORDS_TOTAL-1:0][WORD_W-1:0]   words_q;
    logic                                   load_key, wr_word;
    logic                                   is_rot, is_sub;
    logic [WORD_W-1:0]                      sub_w, w_back8, w_new;
    logic [VEC_W-1:0]                       rk_vec;

    // i%8==0 takes RotWord+SubWord+rcon, i%8==4 takes SubWord only.
    assign is_rot  = (idx_q[2:0] == 3'd0);
    assign is_sub  = (idx_q[1:0] == 2'd0);
    assign w_back8 = words_q[idx_q - 6'd8];

    aes_key_expansion_seq_subword u_subword (
        .t_i   (last_q),
        .rot_i (is_rot),
        .sub_o (sub_w)
    );

    assign w_new = w_back8 ^ (is_sub ? (sub_w ^ {(is_rot ? rcon_q : 8'h00), 24'h0}) : last_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rcon_d   = rcon_q;
        valid_d  = valid_q;
        last_d   = last_q;
        load_key = 1'b0;
        wr_word  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_key_valid) begin
                    load_key = 1'b1;
                    idx_d    = 6'd8;
                    rcon_d   = 8'h01;
                    valid_d  = 1'b0;
                    last_d   = bus.i_key[WORD_W-1:0];
                    state_d  = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                wr_word = 1'b1;
                last_d  = w_new;
                idx_d   = idx_q + 6'd1;
                if (is_rot) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == 6'(N_WORDS_TOTAL - 1)) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            last_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            if (load_key) begin
                for (int j = 0; j < N_WORDS_KEY; j++) begin
                    words_q[j] <= bus.i_key[AES_NB_KEY-1-WORD_W*j -: WORD_W];
                end
            end else if (wr_word) begin
                words_q[idx_q] <= w_new;
            end
        end
    end

    // Round key k occupies [k*128 +: 128] with its first word in the top 32 bits.
    for (genvar i = 0; i < N_WORDS_TOTAL; i++) begin : g_out
        assign rk_vec[(i/4)*RK_W + (3 - i%4)*WORD_W +: WORD_W] = words_q[i];
    end

    assign bus.o_round_key_vector = rk_vec;
    assign bus.o_ready            = (state_q == ST_IDLE);
    assign bus.o_valid            = valid_q;

endmodule
